// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer between the UART receiver and the APB register
//   file. Bytes pushed by the receiver are held in order until the APB read
//   path pops them. The head entry is presented first-word-fall-through.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wr_data      received byte from the UART receiver
//   wr_valid     one-cycle push request for wr_data
//   rd_en        one-cycle pop request from the APB data-register read
//   rd_data      head entry, 8'h00 while empty
//   flush        synchronous clear of the FIFO contents (highest priority)
//   overrun_clr  clears the sticky overrun flag
//   thresh       interrupt threshold in entries, 0 disables the interrupt
//   level        number of stored entries, 0..DEPTH
//   empty        level == 0
//   full         level == DEPTH
//   overrun      sticky: a byte was dropped because the FIFO was full
//   thresh_irq   level >= thresh and thresh != 0
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        wr_data,
   input  logic              wr_valid,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   input  logic              flush,
   input  logic              overrun_clr,
   input  logic [ADDR_W:0]   thresh,
   output logic [ADDR_W:0]   level,
   output logic              empty,
   output logic              full,
   output logic              overrun,
   output logic              thresh_irq
);

   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W + 1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              overrun_q, overrun_d;

   logic              empty_w, full_w;
   logic              do_push, do_pop, drop;

   assign empty_w = (level_q == '0);
   assign full_w  = (level_q == DEPTH_LVL);

   // A pop on a full FIFO frees the slot the simultaneous write needs, so the
   // write is accepted. A pop on an empty FIFO is ignored even when a write
   // arrives in the same cycle, which keeps level from underflowing.
   assign do_pop  = rd_en && !empty_w && !flush;
   assign do_push = wr_valid && (!full_w || rd_en) && !flush;
   assign drop    = wr_valid && full_w && !rd_en && !flush;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      overrun_d = overrun_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end

      // Set has priority over clear so a drop is never lost.
      if (drop)             overrun_d = 1'b1;
      else if (overrun_clr) overrun_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data    = empty_w ? 8'h00 : mem_q[rd_ptr_q];
   assign level      = level_q;
   assign empty      = empty_w;
   assign full       = full_w;
   assign overrun    = overrun_q;
   assign thresh_irq = (thresh != '0) && (level_q >= thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo. Every accepted byte is pushed onto a
//   scoreboard queue; every pop compares the DUT head against the queue front.
//   Status outputs are compared against values derived from the queue.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic [7:0]        wr_data;
   logic              wr_valid;
   logic              rd_en;
   logic [7:0]        rd_data;
   logic              flush;
   logic              overrun_clr;
   logic [ADDR_W:0]   thresh;
   logic [ADDR_W:0]   level;
   logic              empty;
   logic              full;
   logic              overrun;
   logic              thresh_irq;

   int                n_checks = 0;
   int                n_fail   = 0;
   logic [7:0]        sb[$];
   logic              exp_ovr;

   uart_rx_fifo #(.ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .flush       (flush),
      .overrun_clr (overrun_clr),
      .thresh      (thresh),
      .level       (level),
      .empty       (empty),
      .full        (full),
      .overrun     (overrun),
      .thresh_irq  (thresh_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the scoreboard-derived state.
   task automatic check_state(input string tag);
      logic [7:0] exp_head;
      int         n;
      n        = sb.size();
      exp_head = (n == 0) ? 8'h00 : sb[0];
      check({tag, ".level"},   32'(level),      32'(n));
      check({tag, ".empty"},   32'(empty),      32'(n == 0));
      check({tag, ".full"},    32'(full),       32'(n == DEPTH));
      check({tag, ".overrun"}, 32'(overrun),    32'(exp_ovr));
      check({tag, ".rd_data"}, 32'(rd_data),    32'(exp_head));
      check({tag, ".irq"},     32'(thresh_irq), 32'((thresh != 0) && (n >= int'(thresh))));
   endtask

   // One clock of stimulus; the scoreboard is updated to the expected outcome.
   task automatic op(input logic psh, input logic [7:0] d, input logic pp,
                     input logic fl, input logic clr, input string tag);
      logic dropped;
      dropped = 1'b0;
      if (pp && sb.size() > 0 && !fl) begin
         check({tag, ".head"}, 32'(rd_data), 32'(sb[0]));
      end
      if (fl) begin
         sb.delete();
      end else begin
         if (psh && sb.size() == DEPTH && !pp) begin
            dropped = 1'b1;
            exp_ovr = 1'b1;
         end else begin
            if (pp && sb.size() > 0) void'(sb.pop_front());
            if (psh) sb.push_back(d);
         end
      end
      if (clr && !dropped) exp_ovr = 1'b0;

      wr_valid    = psh;
      wr_data     = d;
      rd_en       = pp;
      flush       = fl;
      overrun_clr = clr;
      @(posedge clk);
      #1;
      wr_valid    = 1'b0;
      rd_en       = 1'b0;
      flush       = 1'b0;
      overrun_clr = 1'b0;
      check_state(tag);
   endtask

   initial begin
      rst_n       = 1'b0;
      wr_data     = 8'h00;
      wr_valid    = 1'b0;
      rd_en       = 1'b0;
      flush       = 1'b0;
      overrun_clr = 1'b0;
      thresh      = '0;
      exp_ovr     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_state("reset");

      // 1: pop on empty FIFO is ignored
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_empty");

      // 2: two bytes in, two out
      op(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "push_a5");
      check("t2.head_a5", 32'(rd_data), 32'h0000_00A5);
      op(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, "push_3c");
      check("t2.level2", 32'(level), 32'd2);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_a5");
      check("t2.head_3c", 32'(rd_data), 32'h0000_003C);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_3c");

      // 3: overfill by one, then drain
      for (int i = 0; i <= DEPTH; i++) op(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill17");
      check("t3.level16", 32'(level), 32'd16);
      check("t3.overrun", 32'(overrun), 32'd1);
      for (int i = 0; i < DEPTH; i++) op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain16");
      op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "ovr_clr");

      // 4: simultaneous push/pop when full and when empty
      for (int i = 0; i < DEPTH; i++) op(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, "fill_full");
      op(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, "pushpop_full");
      check("t4.level_full", 32'(level), 32'd16);
      for (int i = 0; i < DEPTH; i++) op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain_full");
      op(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, "pushpop_empty");
      check("t4.level1", 32'(level), 32'd1);
      check("t4.data77", 32'(rd_data), 32'h0000_0077);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_77");

      // 5: threshold interrupt
      thresh = 5'd4;
      for (int i = 0; i < 4; i++) op(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0, "thr_push");
      check("t5.irq_on", 32'(thresh_irq), 32'd1);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "thr_pop");
      check("t5.irq_off", 32'(thresh_irq), 32'd0);
      thresh = 5'd0;
      op(1'b1, 8'h94, 1'b0, 1'b0, 1'b0, "thr_zero");
      thresh = 5'd17;
      for (int i = 0; i < 12; i++) op(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, "thr_above");
      thresh = 5'd0;

      // 6: flush with a concurrent push, then wrap pointers
      op(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush_pre");
      for (int i = 0; i < 5; i++) op(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "fill5");
      op(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, "flush_push");
      check("t6.level0", 32'(level), 32'd0);
      op(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "wrap_seed");
      for (int i = 0; i < 40; i++)
         op(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, "wrap_pair");
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wrap_drain");

      // overrun_clr together with a dropped push keeps overrun set
      for (int i = 0; i < DEPTH; i++) op(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, "fill_ovr");
      op(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, "drop_and_clr");
      check("t6.ovr_kept", 32'(overrun), 32'd1);
      op(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush_keeps_ovr");
      check("t6.ovr_after_flush", 32'(overrun), 32'd1);
      op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_only");

      // asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) op(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, "pre_reset");
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      exp_ovr = 1'b0;
      check_state("async_reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "post_reset_pop");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
